// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Main control FSM for the multicycle RISC-V core. Each instruction is walked
// through fetch, decode, execute, memory and write-back states; the datapath
// (register file, ALU, IR/PC) is steered by the outputs below.
//
// Optional feature: define CTRL_LUI_AUIPC_EN to decode LUI (0110111) and
// AUIPC (0010111). Without it both opcodes trap.
//
// Parameters
//   TIMEOUT    cycles a memory state may wait for mem_ready before trapping
//              (0 disables the timeout)
//   CNT_W      wait counter width
//
// Ports
//   clk         clock, rising edge
//   reset_n     synchronous active-low reset
//   opcode      IR[6:0]
//   mem_ready   memory completes the current request this cycle
//   mem_req     memory access requested
//   mem_we      write access
//   iord        memory address select: 0 = PC, 1 = ALUOut
//   ir_write    load IR from memory read data
//   pc_write    load PC
//   pc_src      PC source: 00 = ALU result, 01 = ALUOut
//   branch      conditional PC load
//   alu_src_a   00 = PC, 01 = rs1, 10 = oldPC, 11 = zero
//   alu_src_b   00 = rs2, 01 = const 4, 10 = immediate
//   alu_op      00 = add, 01 = branch, 10 = R/I-type, 11 = JAL/JALR
//   reg_write   write rd
//   mem_to_reg  rd data: 00 = ALUOut, 01 = MDR, 10 = PC
//   trap        sticky error (illegal opcode or memory timeout)
//   state       current state encoding, for debug
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       branch,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StExecR   = 4'd3,
        StExecI   = 4'd4,
        StMemAddr = 4'd5,
        StMemRd   = 4'd6,
        StMemWr   = 4'd7,
        StWbAlu   = 4'd8,
        StWbMem   = 4'd9,
        StBranch  = 4'd10,
        StJal     = 4'd11,
        StJalr    = 4'd12,
        StTrap    = 4'd13,
        StLui     = 4'd14,
        StAuipc   = 4'd15
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       branch;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       trap;
    } ctrl_t;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
`ifdef CTRL_LUI_AUIPC_EN
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
`endif

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             in_mem_state;
    logic             timeout_hit;

    assign in_mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == CntLast) && !mem_ready;

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    state_d = StFetch;
            StFetch: begin
                if (mem_ready)        state_d = StDecode;
                else if (timeout_hit) state_d = StTrap;
            end
            StDecode: begin
                case (opcode)
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpLoad, OpStore: state_d = StMemAddr;
                    OpBr:            state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
`ifdef CTRL_LUI_AUIPC_EN
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
`endif
                    default:         state_d = StTrap;
                endcase
            end
            StExecR, StExecI: state_d = StWbAlu;
            // IR is still held here, so the opcode picks load vs store.
            StMemAddr: state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready)        state_d = StWbMem;
                else if (timeout_hit) state_d = StTrap;
            end
            StMemWr: begin
                if (mem_ready)        state_d = StFetch;
                else if (timeout_hit) state_d = StTrap;
            end
            StWbAlu, StWbMem, StBranch, StJal, StJalr: state_d = StFetch;
            StTrap:    state_d = StTrap;
            StLui, StAuipc: state_d = StWbAlu;
            default:   state_d = StTrap;
        endcase
    end

    // Wait counter: any state change clears it, so it starts at 0 on entry
    // to each memory state. Saturates rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_mem_state && !mem_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs for the state being entered; registered so they are a pure
    // function of the state register.
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            StIdle: ;
            StFetch: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
            end
            StDecode: begin
                ctrl_d.alu_src_a = 2'b10;
                ctrl_d.alu_src_b = 2'b10;
            end
            StExecR: begin
                ctrl_d.alu_src_a = 2'b01;
                ctrl_d.alu_op    = 2'b10;
            end
            StExecI: begin
                ctrl_d.alu_src_a = 2'b01;
                ctrl_d.alu_src_b = 2'b10;
                ctrl_d.alu_op    = 2'b10;
            end
            StMemAddr: begin
                ctrl_d.alu_src_a = 2'b01;
                ctrl_d.alu_src_b = 2'b10;
            end
            StMemRd: begin
                ctrl_d.mem_req = 1'b1;
                ctrl_d.iord    = 1'b1;
            end
            StMemWr: begin
                ctrl_d.mem_req = 1'b1;
                ctrl_d.mem_we  = 1'b1;
                ctrl_d.iord    = 1'b1;
            end
            StWbAlu: ctrl_d.reg_write = 1'b1;
            StWbMem: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 2'b01;
            end
            StBranch: begin
                ctrl_d.alu_src_a = 2'b01;
                ctrl_d.alu_op    = 2'b01;
                ctrl_d.branch    = 1'b1;
                ctrl_d.pc_src    = 2'b01;
            end
            StJal: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 2'b10;
                ctrl_d.pc_write   = 1'b1;
                ctrl_d.pc_src     = 2'b01;
                ctrl_d.alu_op     = 2'b11;
            end
            StJalr: begin
                ctrl_d.alu_src_a  = 2'b01;
                ctrl_d.alu_src_b  = 2'b10;
                ctrl_d.alu_op     = 2'b11;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 2'b10;
                ctrl_d.pc_write   = 1'b1;
            end
            StTrap: ctrl_d.trap = 1'b1;
            StLui: begin
                ctrl_d.alu_src_a = 2'b11;
                ctrl_d.alu_src_b = 2'b10;
            end
            StAuipc: begin
                ctrl_d.alu_src_a = 2'b10;
                ctrl_d.alu_src_b = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // IR/PC load in FETCH must coincide with the cycle the read data is valid.
    assign ir_write   = (state_q == StFetch) && mem_ready;
    assign pc_write   = ctrl_q.pc_write || ((state_q == StFetch) && mem_ready);

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign iord       = ctrl_q.iord;
    assign pc_src     = ctrl_q.pc_src;
    assign branch     = ctrl_q.branch;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign trap       = ctrl_q.trap;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. A reference model turns each
// instruction (opcode class plus memory wait counts) into the expected
// per-cycle state/output trace, which is then replayed against the DUT.
module tb_multicycle_controller;

    localparam int unsigned TO = 4;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4;
    localparam int S_MEM_ADDR = 5, S_MEM_RD = 6, S_MEM_WR = 7, S_WB_ALU = 8, S_WB_MEM = 9;
    localparam int S_BRANCH = 10, S_JAL = 11, S_JALR = 12, S_TRAP = 13, S_LUI = 14;
    localparam int S_AUIPC = 15;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, branch, reg_write, trap;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
    logic [3:0] state;
    logic [17:0] got;

    int errors = 0;
    int checks = 0;
    bit rand_fill = 1'b0;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic [6:0] opc;
    } cyc_t;
    cyc_t q[$];

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .branch     (branch),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .trap       (trap),
        .state      (state)
    );

    assign got = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, branch,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, trap};

    // Expected output vector for a state, as the per-state output table reads.
    function automatic logic [17:0] exp_out(input int st, input logic rdy);
        logic req, we, io, irw, pcw, br, rw, tr;
        logic [1:0] ps, a, b, op, m2r;
        {req, we, io, irw, pcw, br, rw, tr} = '0;
        {ps, a, b, op, m2r} = '0;
        case (st)
            S_FETCH:    begin req = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:   begin a = 2'b10; b = 2'b10; end
            S_EXEC_R:   begin a = 2'b01; op = 2'b10; end
            S_EXEC_I:   begin a = 2'b01; b = 2'b10; op = 2'b10; end
            S_MEM_ADDR: begin a = 2'b01; b = 2'b10; end
            S_MEM_RD:   begin req = 1; io = 1; end
            S_MEM_WR:   begin req = 1; we = 1; io = 1; end
            S_WB_ALU:   rw = 1;
            S_WB_MEM:   begin rw = 1; m2r = 2'b01; end
            S_BRANCH:   begin a = 2'b01; op = 2'b01; br = 1; ps = 2'b01; end
            S_JAL:      begin rw = 1; m2r = 2'b10; pcw = 1; ps = 2'b01; op = 2'b11; end
            S_JALR: begin
                a = 2'b01; b = 2'b10; op = 2'b11; rw = 1; m2r = 2'b10; pcw = 1;
            end
            S_TRAP:     tr = 1;
            S_LUI:      begin a = 2'b11; b = 2'b10; end
            S_AUIPC:    begin a = 2'b10; b = 2'b10; end
            default: ;
        endcase
        return {req, we, io, irw, pcw, ps, br, a, b, op, rw, m2r, tr};
    endfunction

    function automatic logic fill();
        return rand_fill ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic push(input int st, input logic rdy, input logic [6:0] opc);
        cyc_t c;
        c.st  = 4'(st);
        c.rdy = rdy;
        c.opc = opc;
        q.push_back(c);
    endtask

    task automatic push_trap(input logic [6:0] opc);
        for (int i = 0; i < 3; i++) push(S_TRAP, fill(), opc);
    endtask

    // A memory state with w wait cycles: TO or more waits end in TRAP.
    task automatic mem_phase(input int st, input int w, input logic [6:0] opc,
                             output bit trapped);
        if (w >= int'(TO)) begin
            for (int i = 0; i < int'(TO); i++) push(st, 1'b0, opc);
            push_trap(opc);
            trapped = 1'b1;
        end else begin
            for (int i = 0; i < w; i++) push(st, 1'b0, opc);
            push(st, 1'b1, opc);
            trapped = 1'b0;
        end
    endtask

    task automatic add_instr(input logic [6:0] opc, input int wf, input int wm);
        bit t;
        mem_phase(S_FETCH, wf, opc, t);
        if (t) return;
        push(S_DECODE, fill(), opc);
        case (opc)
            OP_R:    begin push(S_EXEC_R, fill(), opc); push(S_WB_ALU, fill(), opc); end
            OP_I:    begin push(S_EXEC_I, fill(), opc); push(S_WB_ALU, fill(), opc); end
            OP_LW: begin
                push(S_MEM_ADDR, fill(), opc);
                mem_phase(S_MEM_RD, wm, opc, t);
                if (!t) push(S_WB_MEM, fill(), opc);
            end
            OP_SW: begin
                push(S_MEM_ADDR, fill(), opc);
                mem_phase(S_MEM_WR, wm, opc, t);
            end
            OP_BR:   push(S_BRANCH, fill(), opc);
            OP_JAL:  push(S_JAL, fill(), opc);
            OP_JALR: push(S_JALR, fill(), opc);
`ifdef CTRL_LUI_AUIPC_EN
            OP_LUI:   begin push(S_LUI, fill(), opc); push(S_WB_ALU, fill(), opc); end
            OP_AUIPC: begin push(S_AUIPC, fill(), opc); push(S_WB_ALU, fill(), opc); end
`endif
            default: push_trap(opc);
        endcase
    endtask

    task automatic check(input string tag, input logic [17:0] g, input logic [17:0] e);
        checks++;
        assert (g === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, g, e);
        end
    endtask

    // Replays the expected trace, one record per clock cycle.
    task automatic run_queue(input string tag);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            opcode    = c.opc;
            mem_ready = c.rdy;
            #1;
            check({tag, "_state"}, 18'(state), 18'(c.st));
            check({tag, "_outs"}, got, exp_out(int'(c.st), c.rdy));
        end
    endtask

    // Holds reset for n edges; releases it in the last cycle so the next
    // edge moves IDLE -> FETCH.
    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            opcode    = 7'($urandom);
            #1;
            check("rst_state", 18'(state), 18'(S_IDLE));
            check("rst_outs", got, '0);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        logic [6:0] ops [7];
        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};

        do_reset(3);

        // add with zero-wait memory
        rand_fill = 1'b0;
        add_instr(OP_R, 0, 0);
        run_queue("add");

        // LW with 3 wait cycles in MEM_RD
        add_instr(OP_LW, 0, 3);
        run_queue("lw_wait");

        // Random legal instruction stream with 0..3 wait cycles
        rand_fill = 1'b1;
        repeat (40) begin
            add_instr(ops[$urandom_range(0, 6)], int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
            run_queue("rand");
        end

        // JALR, then reset asserted while in JALR
        add_instr(OP_JALR, 1, 0);
        run_queue("jalr");
        do_reset(2);

        // LUI / AUIPC: decoded when enabled, trap otherwise
        add_instr(OP_LUI, 0, 0);
        run_queue("lui");
        do_reset(2);
        add_instr(OP_AUIPC, 0, 0);
        run_queue("auipc");
        do_reset(2);

        // Illegal opcode
        add_instr(7'b1111111, 0, 0);
        run_queue("illegal");
        do_reset(2);

        // Timeouts in FETCH, MEM_RD and MEM_WR
        add_instr(OP_R, int'(TO), 0);
        run_queue("to_fetch");
        do_reset(2);
        add_instr(OP_LW, 2, int'(TO));
        run_queue("to_rd");
        do_reset(2);
        add_instr(OP_SW, 0, int'(TO));
        run_queue("to_wr");
        do_reset(1);

        add_instr(OP_SW, 0, 0);
        run_queue("sw_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
